// File: rtl/median_filter_3x3_stream.sv
// ============================================================================
// Module      : median_filter_3x3_stream
// Description : Streaming 3x3 median filter: two line buffers, a 3x3 window
//               and a 3-stage median network. Optional MEDIAN_BYPASS_EN adds
//               a bypass input that selects the window centre pixel instead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module median_filter_3x3_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
`ifdef MEDIAN_BYPASS_EN
    input  logic              bypass,
`endif
    output logic              out_valid,
    output logic              out_sof,
    output logic [DATA_W-1:0] out_data
);

    localparam int                 c_COL_W    = $clog2(IMG_W);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);

    function automatic logic [DATA_W-1:0] f_min(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] f_med3(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] c);
        return f_max(f_min(a, b), f_min(f_max(a, b), c));
    endfunction

    // ------------------------------------------------------------------
    // Position tracking
    // ------------------------------------------------------------------
    logic [c_COL_W-1:0] r_col, w_col, w_col_next;
    logic [1:0]         r_row, w_row, w_row_next;
    logic               r_in_frame, r_sof_pend;
    logic               w_win_ok, w_win_sof, w_byp;

`ifdef MEDIAN_BYPASS_EN
    assign w_byp = bypass;
`else
    assign w_byp = 1'b0;
`endif

    always_comb begin
        w_col      = in_sof ? '0 : r_col;
        w_row      = in_sof ? 2'd0 : r_row;
        w_col_next = (w_col == c_COL_LAST) ? '0 : w_col + c_COL_W'(1);
        w_row_next = w_row;
        if (w_col == c_COL_LAST && w_row != 2'd2) begin
            w_row_next = w_row + 2'd1;
        end
        // r_in_frame keeps pixels arriving after a reset but before any sof out of the output
        w_win_ok  = in_valid && r_in_frame && (w_row == 2'd2) && (w_col >= c_COL_TWO);
        w_win_sof = w_win_ok && r_sof_pend;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= 2'd0;
            r_in_frame <= 1'b0;
            r_sof_pend <= 1'b0;
        end else if (in_valid) begin
            r_col <= w_col_next;
            r_row <= w_row_next;
            if (in_sof) begin
                r_in_frame <= 1'b1;
                r_sof_pend <= 1'b1;
            end else if (w_win_ok) begin
                r_sof_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers (contents intentionally not reset)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb1[w_col] <= r_lb0[w_col];
            r_lb0[w_col] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Window: r_win[row][col], row 0 oldest, col 2 newest
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_win [3][3];
    logic              r_v0, r_sof0, r_byp0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            r_v0   <= 1'b0;
            r_sof0 <= 1'b0;
            r_byp0 <= 1'b0;
        end else begin
            r_v0   <= w_win_ok;
            r_sof0 <= w_win_sof;
            if (in_valid) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= r_lb1[w_col];
                r_win[1][2] <= r_lb0[w_col];
                r_win[2][2] <= in_data;
                r_byp0      <= w_byp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Median network: row sort, column reduce, final med3
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_s1_min [3];
    logic [DATA_W-1:0] r_s1_mid [3];
    logic [DATA_W-1:0] r_s1_max [3];
    logic [DATA_W-1:0] r_s1_ctr, r_s2_ctr;
    logic [DATA_W-1:0] r_s2_lo, r_s2_md, r_s2_hi;
    logic              r_v1, r_sof1, r_byp1;
    logic              r_v2, r_sof2, r_byp2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                r_s1_min[r] <= '0;
                r_s1_mid[r] <= '0;
                r_s1_max[r] <= '0;
            end
            r_s1_ctr  <= '0;
            r_s2_ctr  <= '0;
            r_s2_lo   <= '0;
            r_s2_md   <= '0;
            r_s2_hi   <= '0;
            r_v1      <= 1'b0;
            r_sof1    <= 1'b0;
            r_byp1    <= 1'b0;
            r_v2      <= 1'b0;
            r_sof2    <= 1'b0;
            r_byp2    <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_data  <= '0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                r_s1_min[r] <= f_min(f_min(r_win[r][0], r_win[r][1]), r_win[r][2]);
                r_s1_mid[r] <= f_med3(r_win[r][0], r_win[r][1], r_win[r][2]);
                r_s1_max[r] <= f_max(f_max(r_win[r][0], r_win[r][1]), r_win[r][2]);
            end
            r_s1_ctr <= r_win[1][1];
            r_v1     <= r_v0;
            r_sof1   <= r_sof0;
            r_byp1   <= r_byp0;

            r_s2_lo  <= f_max(f_max(r_s1_min[0], r_s1_min[1]), r_s1_min[2]);
            r_s2_md  <= f_med3(r_s1_mid[0], r_s1_mid[1], r_s1_mid[2]);
            r_s2_hi  <= f_min(f_min(r_s1_max[0], r_s1_max[1]), r_s1_max[2]);
            r_s2_ctr <= r_s1_ctr;
            r_v2     <= r_v1;
            r_sof2   <= r_sof1;
            r_byp2   <= r_byp1;

            out_valid <= r_v2;
            out_sof   <= r_sof2;
            if (r_v2) begin
                out_data <= r_byp2 ? r_s2_ctr : f_med3(r_s2_lo, r_s2_md, r_s2_hi);
            end
        end
    end

endmodule

`default_nettype wire
